// File: rtl/note_lane_pkg.sv
// Shared types and constants for the note lane drawer.
// Holds the FSM state enum, pixel colour codes and the colour priority helper.
package note_lane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] COL_RED = 3'b100;
    localparam logic [2:0] COL_YEL = 3'b110;
    localparam logic [2:0] COL_BG  = 3'b000;

    // Red has priority over yellow when a slot carries both notes.
    function automatic logic [2:0] pick_colour(
        input logic r,
        input logic yl
    );
        if (r)
            return COL_RED;
        else if (yl)
            return COL_YEL;
        else
            return COL_BG;
    endfunction

endpackage

// File: rtl/note_lane_drawer_pixel_scan_counter.sv
// Row-major dx/dy scan over one SQ_W x SQ_W square.
// Ports: clk, reset (async, active-high), en (advance one pixel),
// dx/dy (current pixel offset), eos (en on the square's last pixel).
module pixel_scan_counter #(
    parameter int SQ_W = 4,
    parameter int DW   = (SQ_W > 1) ? $clog2(SQ_W) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [DW-1:0] dx,
    output logic [DW-1:0] dy,
    output logic          eos
);

    localparam logic [DW-1:0] LAST = DW'(SQ_W - 1);

    assign eos = en && (dx == LAST) && (dy == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            if (dx == LAST) begin
                dx <= '0;
                dy <= (dy == LAST) ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_lane_drawer.sv
// Draws a lane of NUM_SLOTS note squares, one pixel per clock, to a VGA adapter.
// Ports: clk, reset (async, active-high), start, red_seq/yel_seq (note bits);
// x/y/colour/plot (registered pixel write), busy, done (completion pulse).
// Macro NOTE_LANE_SKIP_EMPTY_EN: empty slots take one non-plot cycle instead
// of being erased pixel by pixel.
module note_lane_drawer
    import note_lane_pkg::*;
#(
    parameter int NUM_SLOTS  = 10,
    parameter int SQ_W       = 4,
    parameter int SLOT_PITCH = 8,
    parameter int BASE_X     = 8,
    parameter int BASE_Y     = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] red_seq,
    input  logic [NUM_SLOTS-1:0] yel_seq,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int DW = (SQ_W > 1) ? $clog2(SQ_W) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);

    state_t               state;
    logic [NUM_SLOTS-1:0] red_q;
    logic [NUM_SLOTS-1:0] yel_q;
    logic [NUM_SLOTS-1:0] src_r;
    logic [NUM_SLOTS-1:0] src_y;
    logic [SW-1:0]        slot;
    logic [DW-1:0]        dx;
    logic [DW-1:0]        dy;
    logic                 fin;
    logic                 eos;
    logic                 emit;
    logic                 skip;
    logic                 cnt_en;
    logic                 slot_adv;
    logic                 last;
    logic                 cur_r;
    logic                 cur_y;
    logic [7:0]           px;
    logic [6:0]           py;

    // The scan counters always point at the pixel to emit next; the
    // accepting edge emits pixel 0 straight from the live inputs so the
    // first plot appears the cycle right after start is taken.
    assign emit = (state == ST_IDLE && start)
               || (state == ST_DRAW && !fin);
    assign src_r = (state == ST_IDLE) ? red_seq : red_q;
    assign src_y = (state == ST_IDLE) ? yel_seq : yel_q;
    assign cur_r = src_r[slot];
    assign cur_y = src_y[slot];

`ifdef NOTE_LANE_SKIP_EMPTY_EN
    assign skip = !(cur_r || cur_y);
`else
    assign skip = 1'b0;
`endif

    assign cnt_en   = emit && !skip;
    assign slot_adv = emit && (skip || eos);
    assign last     = slot_adv && (slot == LAST_SLOT);

    assign px = 8'(32'(BASE_X) + 32'(slot) * 32'(SLOT_PITCH) + 32'(dx));
    assign py = 7'(32'(BASE_Y) + 32'(dy));

    pixel_scan_counter #(
        .SQ_W (SQ_W),
        .DW   (DW)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .dx    (dx),
        .dy    (dy),
        .eos   (eos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            red_q  <= '0;
            yel_q  <= '0;
            slot   <= '0;
            fin    <= 1'b0;
        end else begin
            done <= 1'b0;
            plot <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_DRAW;
                        busy  <= 1'b1;
                        red_q <= red_seq;
                        yel_q <= yel_seq;
                    end
                end
                ST_DRAW: begin
                    // fin marks that the final pixel has been emitted.
                    if (fin) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        fin   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
            if (cnt_en) begin
                plot   <= 1'b1;
                x      <= px;
                y      <= py;
                colour <= pick_colour(cur_r, cur_y);
            end
            if (slot_adv)
                slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            if (last)
                fin <= 1'b1;
        end
    end

endmodule

// File: tb/tb_note_lane_drawer.sv
// Self-checking bench for note_lane_drawer: frame-level model plus
// directed frames with literal expectations.
module tb_note_lane_drawer;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] red_seq = '0;
    logic [9:0] yel_seq = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    logic       start2 = 1'b0;
    logic [1:0] red2 = '0;
    logic [1:0] yel2 = '0;
    logic [7:0] x2;
    logic [6:0] y2;
    logic [2:0] col2;
    logic       plot2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        exp_q[$];
    logic        model_busy = 1'b0;
    logic [7:0]  lx = '0;
    logic [6:0]  ly = '0;
    logic [2:0]  lc = '0;
    logic [17:0] seen[$];
    logic [17:0] seen2[$];

    always #5 clk = ~clk;

    note_lane_drawer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .red_seq (red_seq),
        .yel_seq (yel_seq),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    note_lane_drawer #(
        .NUM_SLOTS (2),
        .BASE_X    (250)
    ) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .red_seq (red2),
        .yel_seq (yel2),
        .x       (x2),
        .y       (y2),
        .colour  (col2),
        .plot    (plot2),
        .busy    (busy2),
        .done    (done2)
    );

    function automatic void chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)",
                     name, act, req, $time);
        end
    endfunction

    function automatic int pix(int px, int py, int pc);
        return (px << 10) | (py << 3) | pc;
    endfunction

    function automatic int at(int idx);
        if (idx < seen.size())
            return int'(seen[idx]);
        return -1;
    endfunction

    function automatic int at2(int idx);
        if (idx < seen2.size())
            return int'(seen2[idx]);
        return -1;
    endfunction

    // Expected output trace of one whole frame, one entry per cycle,
    // from the accept edge's next cycle through the done cycle.
    function automatic void build(logic [9:0] r, logic [9:0] yl);
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic [2:0] c;
        px = lx;
        py = ly;
        pc = lc;
        for (int s = 0; s < 10; s++) begin
            c = r[s] ? 3'b100 : (yl[s] ? 3'b110 : 3'b000);
`ifdef NOTE_LANE_SKIP_EMPTY_EN
            if (!r[s] && !yl[s]) begin
                exp_q.push_back('{1'b0, px, py, pc, 1'b1, 1'b0});
                continue;
            end
`endif
            for (int dy = 0; dy < 4; dy++)
                for (int dx = 0; dx < 4; dx++) begin
                    px = 8'((8 + s * 8 + dx) % 256);
                    py = 7'((56 + dy) % 128);
                    pc = c;
                    exp_q.push_back('{1'b1, px, py, pc, 1'b1, 1'b0});
                end
        end
        exp_q.push_back('{1'b0, px, py, pc, 1'b1, 1'b1});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0)
            e = exp_q.pop_front();
        else
            e = '{1'b0, lx, ly, lc, 1'b0, 1'b0};
        chk("plot", int'(plot), int'(e.plot));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("x", int'(x), int'(e.x));
        chk("y", int'(y), int'(e.y));
        chk("colour", int'(colour), int'(e.col));
        model_busy = e.busy;
        lx = e.x;
        ly = e.y;
        lc = e.col;
    end

    task automatic frame(input logic [9:0] r, input logic [9:0] yl,
                         input int rp, output int plots,
                         output int done_at);
        plots = 0;
        done_at = -1;
        seen.delete();
        @(posedge clk);
        #1;
        red_seq = r;
        yel_seq = yl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!model_busy)
            build(r, yl);
        red_seq = ~r;
        yel_seq = ~yl;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (plot) begin
                plots++;
                seen.push_back({x, y, colour});
            end
            if (done) begin
                done_at = i;
                break;
            end
            start = (i == rp);
        end
        start = 1'b0;
        if (done_at < 0)
            chk("frame_timeout", 0, 1);
    endtask

    initial begin
        int p, d, base, d2;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        frame(10'b0110101010, 10'b0, 0, p, d);
`ifdef NOTE_LANE_SKIP_EMPTY_EN
        chk("f1_plots", p, 80);
        chk("f1_done_at", d, 86);
        chk("f1_first", at(0), pix(16, 56, 4));
`else
        chk("f1_plots", p, 160);
        chk("f1_done_at", d, 161);
        chk("f1_first", at(0), pix(8, 56, 0));
        chk("f1_slot1", at(16), pix(16, 56, 4));
        chk("f1_lastpix", at(159), pix(83, 59, 0));
`endif

        frame(10'b0000001000, 10'b0000001000, 0, p, d);
`ifdef NOTE_LANE_SKIP_EMPTY_EN
        base = 0;
        chk("f2_plots", p, 16);
`else
        base = 48;
        chk("f2_plots", p, 160);
`endif
        for (int j = 0; j < 16; j++)
            chk("f2_slot3", at(base + j),
                pix(32 + j % 4, 56 + j / 4, 4));

        frame(10'b1111111111, 10'b0101010101, 20, p, d);
        chk("f3_plots", p, 160);
        chk("f3_done_at", d, 161);

        frame(10'b0000000011, 10'b0000000110, 0, p, d);
        chk("f4_slot0", at(0), pix(8, 56, 4));
        chk("f4_slot1", at(16), pix(16, 56, 4));
        chk("f4_slot2", at(32), pix(24, 56, 6));
`ifdef NOTE_LANE_SKIP_EMPTY_EN
        chk("f4_plots", p, 48);
        chk("f4_done_at", d, 56);
`else
        chk("f4_plots", p, 160);
        chk("f4_done_at", d, 161);
`endif

        frame(10'b0000000001, 10'b0, 0, p, d);
`ifdef NOTE_LANE_SKIP_EMPTY_EN
        chk("f5_plots", p, 16);
        chk("f5_done_at", d, 26);
`else
        chk("f5_plots", p, 160);
        chk("f5_done_at", d, 161);
        chk("f5_erase", at(16), pix(16, 56, 0));
`endif

        @(posedge clk);
        #1;
        red_seq = 10'b1111111111;
        yel_seq = 10'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!model_busy)
            build(red_seq, yel_seq);
        repeat (50) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_busy = 1'b0;
        lx = '0;
        ly = '0;
        lc = '0;
        #1;
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_x", int'(x), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        frame(10'b1111111111, 10'b0, 0, p, d);
        chk("f6_first", at(0), pix(8, 56, 4));
        chk("f6_plots", p, 160);

        seen2.delete();
        d2 = -1;
        @(posedge clk);
        #1;
        red2 = 2'b11;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (plot2)
                seen2.push_back({x2, y2, col2});
            if (done2) begin
                d2 = i;
                break;
            end
        end
        chk("w_plots", seen2.size(), 32);
        chk("w_done_at", d2, 33);
        chk("w_s0_first", at2(0), pix(250, 56, 4));
        chk("w_s0_end", at2(3), pix(253, 56, 4));
        chk("w_s1_first", at2(16), pix(2, 56, 4));
        chk("w_s1_end", at2(19), pix(5, 56, 4));
        chk("w_last", at2(31), pix(5, 59, 4));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_lane_drawer.md
NOTE_LANE_DRAWER -- requirements
Module: note_lane_drawer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 10, number of note slots in the lane (legal range 1..16).
REQ-002 SHALL have parameter SQ_W, default 4, note square side in pixels (legal range 1..8).
REQ-003 SHALL have parameter SLOT_PITCH, default 8, horizontal pixel distance between slot origins (must be >= SQ_W).
REQ-004 SHALL have parameter BASE_X, default 8, x origin of slot 0 (8-bit).
REQ-005 SHALL have parameter BASE_Y, default 56, y origin of the lane (7-bit).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1, draw request, sampled only in IDLE.
REQ-009 SHALL have port red_seq, input, NUM_SLOTS, bit s = red note in slot s.
REQ-010 SHALL have port yel_seq, input, NUM_SLOTS, bit s = yellow note in slot s.
REQ-011 SHALL have port x, output, 8, registered pixel x coordinate.
REQ-012 SHALL have port y, output, 7, registered pixel y coordinate.
REQ-013 SHALL have port colour, output, 3, registered pixel colour.
REQ-014 SHALL have port plot, output, 1, pixel write strobe to the VGA adapter.
REQ-015 SHALL have ports busy and done, output, 1 each; busy = draw in progress, done = one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, DRAW, DONE; IDLE->DRAW on start=1, DRAW->DONE after last slot, DONE->IDLE unconditionally next cycle.
REQ-017 SHALL latch red_seq and yel_seq on the accepting edge; input changes during DRAW have no effect.
REQ-018 SHALL ignore start while busy=1 or in DONE.
REQ-019 SHALL scan slots 0..NUM_SLOTS-1 in order, each slot row-major (dx fastest, then dy, 0..SQ_W-1), one pixel per cycle.
REQ-020 SHALL drive x = (BASE_X + s*SLOT_PITCH + dx) mod 256 and y = (BASE_Y + dy) mod 128.
REQ-021 SHALL drive colour 3'b100 if red bit set, else 3'b110 if yellow bit set, else 3'b000 (red wins when both set).
REQ-022 SHALL, with start accepted at edge k, assert plot with the first pixel at cycle k+1, busy from k+1 through the DONE cycle, and done for exactly the DONE cycle.
REQ-023 SHALL hold plot=0 in IDLE and DONE; x/y/colour hold last value when plot=0.
REQ-024 SHALL complete in NUM_SLOTS*SQ_W*SQ_W DRAW cycles when the skip feature is absent.

Reset
REQ-025 SHALL on reset force IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, scan counters and latched sequences 0, immediately (asynchronously).
REQ-026 SHALL, on reset mid-DRAW, abandon the frame; the next accepted start redraws from slot 0, pixel (0,0).

Configuration
REQ-027 SHALL support macro NOTE_LANE_SKIP_EMPTY_EN: when defined, a slot with both bits clear consumes exactly one DRAW cycle with plot=0 and is not drawn.
REQ-028 SHALL, when NOTE_LANE_SKIP_EMPTY_EN is undefined, draw empty slots in full with colour 3'b000 (erase).

Structure
REQ-029 SHALL place colour constants (COL_RED, COL_YEL, COL_BG) and the state enum typedef in shared package note_lane_pkg.
REQ-030 SHALL use one sub-module pixel_scan_counter (dx/dy counter with SQ_W parameter, enable, and end-of-square pulse).

Verification
REQ-031 Defaults, no macro, red_seq=10'b0110101010, yel_seq=0, start at edge k -> 160 plot cycles, first pixel (8,56) colour 000, slot 1 first pixel (16,56) colour 100, done at k+161.
REQ-032 red_seq=yel_seq=10'b0000001000 -> slot 3 pixels (32..35,56..59) all colour 100.
REQ-033 start re-pulsed at k+20 during draw -> no restart, done still at k+161, exactly 160 plot cycles.
REQ-034 reset asserted at pixel 50 -> plot, busy 0 same cycle; next start produces first pixel (8,56) again.
REQ-035 NOTE_LANE_SKIP_EMPTY_EN, red_seq=10'b0000000001, yel_seq=0 -> 16 plot cycles plus 9 non-plot cycles, done at k+26.
REQ-036 BASE_X=250, NUM_SLOTS=2 -> slot 0 x=250..253, slot 1 x wraps to 2..5.
